// File: rtl/bram_fault_inject_ctrl_if.sv
// Port-B sharing bus for bram_fault_inject_ctrl.
// Groups the host load/readback channel, the fault-injection channel and the
// BRAM port B pins. Vectors use MicroBlaze big-endian numbering ([0] is MSB).
//   slave  : the controller (takes requests, drives acks and port B)
//   master : the environment (requesters plus the BRAM read data)
interface bram_fault_inject_ctrl_if #(
  parameter int unsigned C_PORT_AWIDTH = 32,
  parameter int unsigned C_PORT_DWIDTH = 32,
  parameter int unsigned C_NUM_WE      = 4,
  parameter int unsigned C_CNT_WIDTH   = 16
);
  // Host channel
  logic                     host_req;
  logic [0:C_NUM_WE-1]      host_we;
  logic [0:C_PORT_AWIDTH-1] host_addr;
  logic [0:C_PORT_DWIDTH-1] host_wdata;
  logic [0:C_PORT_DWIDTH-1] host_rdata;
  logic                     host_ack;
  // Injection channel
  logic                     inj_req;
  logic [0:C_PORT_AWIDTH-1] inj_addr;
  logic [0:C_PORT_DWIDTH-1] inj_mask;
  logic                     inj_ack;
  logic                     inj_err;
  logic [0:C_CNT_WIDTH-1]   inj_count;
  logic                     busy;
  // BRAM port B
  logic                     bram_en_b;
  logic [0:C_NUM_WE-1]      bram_wen_b;
  logic [0:C_PORT_AWIDTH-1] bram_addr_b;
  logic [0:C_PORT_DWIDTH-1] bram_dout_b;
  logic [0:C_PORT_DWIDTH-1] bram_din_b;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata, inj_req, inj_addr, inj_mask, bram_din_b,
    output host_rdata, host_ack, inj_ack, inj_err, inj_count, busy,
    output bram_en_b, bram_wen_b, bram_addr_b, bram_dout_b
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata, inj_req, inj_addr, inj_mask, bram_din_b,
    input  host_rdata, host_ack, inj_ack, inj_err, inj_count, busy,
    input  bram_en_b, bram_wen_b, bram_addr_b, bram_dout_b
  );
endinterface

// File: rtl/bram_fault_inject_ctrl.sv
// Port-B controller/arbiter for the MicroBlaze local-memory BRAM.
// Shares port B between the host load/readback channel and the fault-injection
// engine (round-robin when both request), and runs each injection as an atomic
// read-XOR-write. Port A is never touched.
// Ports:
//   clk  : single clock, also drives the BRAM port B clock externally
//   rst  : asynchronous active-high reset; aborts any transaction in flight
//   bus  : host channel, injection channel and BRAM port B (slave modport)
// All outputs are registered.
module bram_fault_inject_ctrl #(
  parameter int unsigned C_MEMSIZE     = 'h8000,
  parameter int unsigned C_PORT_AWIDTH = 32,
  parameter int unsigned C_PORT_DWIDTH = 32,
  parameter int unsigned C_NUM_WE      = 4,
  parameter int unsigned C_CNT_WIDTH   = 16
) (
  input logic                     clk,
  input logic                     rst,
  bram_fault_inject_ctrl_if.slave bus
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StHAcc = 3'd1;
  localparam logic [2:0] StHRdw = 3'd2;
  localparam logic [2:0] StIRd  = 3'd3;
  localparam logic [2:0] StIRdw = 3'd4;
  localparam logic [2:0] StIWr  = 3'd5;
  localparam logic [2:0] StAck  = 3'd6;

  localparam logic [0:C_CNT_WIDTH-1] CntMax = {C_CNT_WIDTH{1'b1}};
  localparam logic [0:C_CNT_WIDTH-1] CntOne = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]               state_q, state_d;
  logic                     rr_inj_q, rr_inj_d;  // 1: injector wins the next tie
  logic [0:C_PORT_DWIDTH-1] mask_q, mask_d;
  logic                     host_ack_q, host_ack_d;
  logic                     inj_ack_q, inj_ack_d;
  logic                     inj_err_q, inj_err_d;
  logic                     busy_q, busy_d;
  logic                     en_q, en_d;
  logic [0:C_NUM_WE-1]      wen_q, wen_d;
  logic [0:C_PORT_AWIDTH-1] addr_q, addr_d;
  logic [0:C_PORT_DWIDTH-1] dout_q, dout_d;
  logic [0:C_PORT_DWIDTH-1] rdata_q, rdata_d;
  logic [0:C_CNT_WIDTH-1]   count_q, count_d;

  logic grant_host, grant_inj;

  always_comb begin
    grant_host = bus.host_req && (!bus.inj_req || !rr_inj_q);
    grant_inj  = bus.inj_req && (!bus.host_req || rr_inj_q);
  end

  always_comb begin
    state_d    = state_q;
    rr_inj_d   = rr_inj_q;
    mask_d     = mask_q;
    host_ack_d = 1'b0;
    inj_ack_d  = 1'b0;
    inj_err_d  = 1'b0;
    en_d       = 1'b0;
    wen_d      = '0;
    addr_d     = addr_q;
    dout_d     = dout_q;
    rdata_d    = rdata_q;
    count_d    = count_q;

    unique case (state_q)
      StIdle: begin
        if (grant_host) begin
          state_d  = StHAcc;
          rr_inj_d = 1'b1;
          en_d     = 1'b1;
          wen_d    = bus.host_we;
          addr_d   = {bus.host_addr[0:C_PORT_AWIDTH-3], 2'b00};
          dout_d   = bus.host_wdata;
        end else if (grant_inj) begin
          rr_inj_d = 1'b0;
          mask_d   = bus.inj_mask;
          if (bus.inj_addr >= C_MEMSIZE) begin
            // Out of range: complete with error, port B untouched.
            state_d   = StAck;
            inj_ack_d = 1'b1;
            inj_err_d = 1'b1;
          end else begin
            state_d = StIRd;
            en_d    = 1'b1;
            addr_d  = {bus.inj_addr[0:C_PORT_AWIDTH-3], 2'b00};
          end
        end
      end
      StHAcc: begin
        // The registered write enables still hold the host's WE here.
        if (|wen_q) begin
          state_d    = StAck;
          host_ack_d = 1'b1;
        end else begin
          state_d = StHRdw;
        end
      end
      StHRdw: begin
        state_d    = StAck;
        host_ack_d = 1'b1;
        rdata_d    = bus.bram_din_b;
      end
      StIRd: begin
        state_d = StIRdw;
      end
      StIRdw: begin
        if (mask_q == '0) begin
          state_d   = StAck;
          inj_ack_d = 1'b1;
        end else begin
          state_d = StIWr;
          en_d    = 1'b1;
          wen_d   = '1;
          dout_d  = bus.bram_din_b ^ mask_q;
        end
      end
      StIWr: begin
        state_d   = StAck;
        inj_ack_d = 1'b1;
        if (count_q != CntMax) begin
          count_d = count_q + CntOne;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_inj_q   <= 1'b0;
      mask_q     <= '0;
      host_ack_q <= 1'b0;
      inj_ack_q  <= 1'b0;
      inj_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      en_q       <= 1'b0;
      wen_q      <= '0;
      addr_q     <= '0;
      dout_q     <= '0;
      rdata_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_inj_q   <= rr_inj_d;
      mask_q     <= mask_d;
      host_ack_q <= host_ack_d;
      inj_ack_q  <= inj_ack_d;
      inj_err_q  <= inj_err_d;
      busy_q     <= busy_d;
      en_q       <= en_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      rdata_q    <= rdata_d;
      count_q    <= count_d;
    end
  end

  assign bus.host_rdata  = rdata_q;
  assign bus.host_ack    = host_ack_q;
  assign bus.inj_ack     = inj_ack_q;
  assign bus.inj_err     = inj_err_q;
  assign bus.inj_count   = count_q;
  assign bus.busy        = busy_q;
  assign bus.bram_en_b   = en_q;
  assign bus.bram_wen_b  = wen_q;
  assign bus.bram_addr_b = addr_q;
  assign bus.bram_dout_b = dout_q;

endmodule

// File: tb/tb_bram_fault_inject_ctrl.sv
// Self-checking bench for bram_fault_inject_ctrl: directed vector table,
// randomized operations against a word-level memory/counter model, and
// hand-written contention, saturation and mid-transaction reset sequences.
module tb_bram_fault_inject_ctrl;

  localparam int OpHwr = 0;
  localparam int OpHrd = 1;
  localparam int OpInj = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_fault_inject_ctrl_if bus ();

  bram_fault_inject_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // BRAM port B model: synchronous, one-cycle read latency, byte enables.
  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] dout;
  } acc_t;

  logic [31:0] mem [0:8191] = '{default: 32'h0};
  logic [31:0] rd_q = 32'h0;
  acc_t        log_q [$];

  assign bus.bram_din_b = rd_q;

  always @(posedge clk) begin
    acc_t e;
    int   idx;
    if (bus.bram_en_b) begin
      e.wen  = bus.bram_wen_b;
      e.addr = bus.bram_addr_b;
      e.dout = bus.bram_dout_b;
      idx    = int'(e.addr[14:2]);
      log_q.push_back(e);
      if (e.wen == 4'h0) rd_q <= mem[idx];
      else for (int k = 0; k < 4; k++) if (e.wen[k]) mem[idx][8*k +: 8] <= e.dout[8*k +: 8];
    end
  end

  // Reference model: word contents by word index, and the injection counter.
  logic [31:0] ref_mem [int];
  logic [15:0] cnt_ref;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {7'd0, bus.host_rdata, bus.host_ack, bus.inj_ack, bus.inj_err, bus.inj_count,
            bus.busy, bus.bram_en_b, bus.bram_wen_b, bus.bram_addr_b, bus.bram_dout_b};
  endfunction

  // Expected outcome of one operation, from the behavioural rules.
  task automatic model_op(input int kind, input logic [3:0] we, input logic [31:0] addr,
                          input logic [31:0] data, output int lat, output logic [31:0] rdat,
                          output logic err, output int acc, output logic [31:0] wdat);
    int key;
    logic [31:0] old, nw;
    key  = int'(addr[31:2]);
    old  = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
    err  = 1'b0;
    rdat = 32'h0;
    wdat = 32'h0;
    lat  = 0;
    acc  = 0;
    if (kind == OpHwr) begin
      nw = old;
      for (int k = 0; k < 4; k++) if (we[k]) nw[8*k +: 8] = data[8*k +: 8];
      ref_mem[key] = nw;
      lat = 2; acc = 1; wdat = data;
    end else if (kind == OpHrd) begin
      rdat = old; lat = 3; acc = 1;
    end else if (addr >= 32'h8000) begin
      lat = 1; err = 1'b1; acc = 0;
    end else if (data == 32'h0) begin
      lat = 3; acc = 1;
    end else begin
      wdat = old ^ data;
      ref_mem[key] = wdat;
      lat = 4; acc = 2;
      if (cnt_ref != 16'hFFFF) cnt_ref = cnt_ref + 16'd1;
    end
  endtask

  // Issue one request from an idle controller; lat = cycles from grant edge to Ack.
  task automatic do_op(input int kind, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] data, output int lat, output logic [31:0] rdat,
                       output logic err, output logic [15:0] cnt);
    log_q.delete();
    if (kind == OpInj) begin
      bus.inj_addr = addr;
      bus.inj_mask = data;
      bus.inj_req  = 1'b1;
    end else begin
      bus.host_we    = (kind == OpHwr) ? we : 4'h0;
      bus.host_addr  = addr;
      bus.host_wdata = data;
      bus.host_req   = 1'b1;
    end
    lat = -1; rdat = 32'h0; err = 1'b0; cnt = 16'h0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if ((kind == OpInj) ? bus.inj_ack : bus.host_ack) begin
        lat  = c;
        rdat = bus.host_rdata;
        err  = bus.inj_err;
        cnt  = bus.inj_count;
        break;
      end
    end
    bus.host_req = 1'b0;
    bus.inj_req  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic verify(input string tag, input int kind, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] data, input int e_lat,
                        input logic [31:0] e_rdata, input logic e_err, input logic [15:0] e_cnt,
                        input int e_acc, input logic [31:0] e_wdat);
    int lat;
    logic [31:0] rd, aw;
    logic err;
    logic [15:0] cnt;
    do_op(kind, we, addr, data, lat, rd, err, cnt);
    aw = {addr[31:2], 2'b00};
    check($sformatf("%s latency", tag), lat, e_lat);
    if (kind == OpHrd) check($sformatf("%s rdata", tag), rd, e_rdata);
    if (kind == OpInj) begin
      check($sformatf("%s inj_err", tag), err, e_err);
      check($sformatf("%s inj_count", tag), cnt, e_cnt);
    end
    check($sformatf("%s port accesses", tag), log_q.size(), e_acc);
    if (e_acc >= 1) begin
      check($sformatf("%s addr_b", tag), log_q[0].addr, aw);
      check($sformatf("%s wen_b", tag), log_q[0].wen, (kind == OpHwr) ? we : 4'h0);
      if (kind == OpHwr) check($sformatf("%s dout_b", tag), log_q[0].dout, e_wdat);
    end
    if (e_acc == 2) begin
      check($sformatf("%s rmw wen_b", tag), log_q[1].wen, 4'hF);
      check($sformatf("%s rmw addr_b", tag), log_q[1].addr, aw);
      check($sformatf("%s rmw dout_b", tag), log_q[1].dout, e_wdat);
    end
  endtask

  typedef struct {
    int          kind;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic [15:0] cnt;
    int          acc;
    logic [31:0] wdat;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int m_lat, m_acc, n;
    logic [31:0] m_rd, m_wd, addr, data, hd, mk;
    logic m_err, hdone, idone, saw_ack;
    logic [3:0] we;
    logic [15:0] icnt;
    int ord [4];
    int kind, j;

    vecs[0]  = '{OpHwr, 4'hF, 32'h10,       32'hDEADBEEF, 2, 32'h0,        0, 16'd0, 1, 32'hDEADBEEF};
    vecs[1]  = '{OpHrd, 4'h0, 32'h10,       32'h0,        3, 32'hDEADBEEF, 0, 16'd0, 1, 32'h0};
    vecs[2]  = '{OpHwr, 4'hF, 32'h20,       32'h0000FFFF, 2, 32'h0,        0, 16'd0, 1, 32'h0000FFFF};
    vecs[3]  = '{OpInj, 4'h0, 32'h20,       32'h80000001, 4, 32'h0,        0, 16'd1, 2, 32'h8000FFFE};
    vecs[4]  = '{OpHrd, 4'h0, 32'h20,       32'h0,        3, 32'h8000FFFE, 0, 16'd1, 1, 32'h0};
    vecs[5]  = '{OpInj, 4'h0, 32'h8000,     32'h00000001, 1, 32'h0,        1, 16'd1, 0, 32'h0};
    vecs[6]  = '{OpInj, 4'h0, 32'h20,       32'h0,        3, 32'h0,        0, 16'd1, 1, 32'h0};
    vecs[7]  = '{OpHwr, 4'h8, 32'h13,       32'h11223344, 2, 32'h0,        0, 16'd1, 1, 32'h11223344};
    vecs[8]  = '{OpHrd, 4'h0, 32'h12,       32'h0,        3, 32'h11ADBEEF, 0, 16'd1, 1, 32'h0};
    vecs[9]  = '{OpInj, 4'h0, 32'h7FFC,     32'hFFFFFFFF, 4, 32'h0,        0, 16'd2, 2, 32'hFFFFFFFF};
    vecs[10] = '{OpHrd, 4'h0, 32'h7FFF,     32'h0,        3, 32'hFFFFFFFF, 0, 16'd2, 1, 32'h0};
    vecs[11] = '{OpInj, 4'h0, 32'hFFFFFFFC, 32'h00000005, 1, 32'h0,        1, 16'd2, 0, 32'h0};

    cnt_ref        = 16'h0;
    rst            = 1'b1;
    bus.host_req   = 1'b0;
    bus.host_we    = 4'h0;
    bus.host_addr  = 32'h0;
    bus.host_wdata = 32'h0;
    bus.inj_req    = 1'b0;
    bus.inj_addr   = 32'h0;
    bus.inj_mask   = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("outputs in reset", all_outs(), 128'h0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("outputs after reset", all_outs(), 128'h0);

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      model_op(vecs[i].kind, vecs[i].we, vecs[i].addr, vecs[i].data, m_lat, m_rd, m_err, m_acc,
               m_wd);
      verify($sformatf("vec%0d", i), vecs[i].kind, vecs[i].we, vecs[i].addr, vecs[i].data,
             vecs[i].lat, vecs[i].rdata, vecs[i].err, vecs[i].cnt, vecs[i].acc, vecs[i].wdat);
    end

    // Randomized operations against the model
    for (int i = 0; i < 50; i++) begin
      kind = int'($urandom_range(0, 2));
      we   = 4'($urandom_range(1, 15));
      addr = 32'h100 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      data = $urandom;
      if (kind == OpInj) begin
        j = int'($urandom_range(0, 5));
        if (j == 0) data = 32'h0;
        if (j == 1) addr = 32'h8000 + $urandom_range(0, 32'hFFFF);
      end
      model_op(kind, we, addr, data, m_lat, m_rd, m_err, m_acc, m_wd);
      verify($sformatf("rand%0d", i), kind, we, addr, data, m_lat, m_rd, m_err, cnt_ref, m_acc,
             m_wd);
    end

    // Leave the injector as last served so a tie goes to the host first.
    model_op(OpInj, 4'h0, 32'h9000, 32'h1, m_lat, m_rd, m_err, m_acc, m_wd);
    verify("rr prep", OpInj, 4'h0, 32'h9000, 32'h1, m_lat, m_rd, m_err, cnt_ref, m_acc, m_wd);

    // Simultaneous requests, two rounds back to back
    for (int r = 0; r < 2; r++) begin
      log_q.delete();
      n = 0; hdone = 1'b0; idone = 1'b0; icnt = 16'h0;
      hd = $urandom;
      mk = $urandom | 32'h1;
      bus.host_we = 4'hF; bus.host_addr = 32'h200; bus.host_wdata = hd;
      bus.inj_addr = 32'h204; bus.inj_mask = mk;
      bus.host_req = 1'b1; bus.inj_req = 1'b1;
      for (int c = 0; c < 30 && !(hdone && idone); c++) begin
        @(posedge clk); #1;
        if (bus.host_ack) begin
          bus.host_req = 1'b0; hdone = 1'b1;
          if (n < 2) ord[2*r+n] = 0;
          n++;
        end
        if (bus.inj_ack) begin
          bus.inj_req = 1'b0; idone = 1'b1; icnt = bus.inj_count;
          if (n < 2) ord[2*r+n] = 1;
          n++;
        end
      end
      bus.host_req = 1'b0; bus.inj_req = 1'b0;
      @(posedge clk); #1;
      model_op(OpHwr, 4'hF, 32'h200, hd, m_lat, m_rd, m_err, m_acc, m_wd);
      model_op(OpInj, 4'h0, 32'h204, mk, m_lat, m_rd, m_err, m_acc, m_wd);
      check($sformatf("contend%0d both acked", r), {hdone, idone}, 2'b11);
      check($sformatf("contend%0d inj_count", r), icnt, cnt_ref);
      check($sformatf("contend%0d port accesses", r), log_q.size(), 3);
      j = -1;
      foreach (log_q[k]) if (j < 0 && log_q[k].wen == 4'h0 && log_q[k].addr == 32'h204) j = k;
      check($sformatf("contend%0d rmw write follows read", r),
            {log_q[j+1].wen, log_q[j+1].addr, log_q[j+1].dout}, {4'hF, 32'h204, m_wd});
    end
    check("grant order", {ord[0][0], ord[1][0], ord[2][0], ord[3][0]}, 4'b0101);
    verify("contend readback", OpHrd, 4'h0, 32'h200, 32'h0, 3,
           ref_mem[int'(32'h200 >> 2)], 1'b0, cnt_ref, 1, 32'h0);

    // Counter saturation
    force dut.count_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.count_q;
    cnt_ref = 16'hFFFF;
    model_op(OpInj, 4'h0, 32'h300, 32'h00F0000F, m_lat, m_rd, m_err, m_acc, m_wd);
    verify("saturate", OpInj, 4'h0, 32'h300, 32'h00F0000F, m_lat, m_rd, m_err, cnt_ref, m_acc,
           m_wd);

    // Reset while the injection sits between its read and its write
    model_op(OpHwr, 4'hF, 32'h60, 32'hA5A5_1234, m_lat, m_rd, m_err, m_acc, m_wd);
    verify("pre-reset write", OpHwr, 4'hF, 32'h60, 32'hA5A5_1234, m_lat, m_rd, m_err, cnt_ref,
           m_acc, m_wd);
    bus.inj_addr = 32'h60; bus.inj_mask = 32'h0F0F_0000; bus.inj_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async reset clears outputs", all_outs(), 128'h0);
    bus.inj_req = 1'b0;
    saw_ack = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      saw_ack = saw_ack | bus.inj_ack;
    end
    #2 rst = 1'b0;
    check("no ack across reset", saw_ack, 1'b0);
    check("idle after reset", {bus.busy, bus.inj_count}, 17'h0);
    cnt_ref = 16'h0;
    model_op(OpHrd, 4'h0, 32'h60, 32'h0, m_lat, m_rd, m_err, m_acc, m_wd);
    verify("post-reset read", OpHrd, 4'h0, 32'h60, 32'h0, m_lat, m_rd, m_err, cnt_ref, m_acc,
           m_wd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bram_fault_inject_ctrl.md
Name: bram_fault_inject_ctrl

Overview:
Controller and arbiter for port B of the MicroBlaze local-memory BRAM block. It shares port B between two requesters: the host load/readback channel and the fault-injection engine. It also sequences bit-flip injections as atomic read-XOR-write transactions. Port A stays owned by the processor; this block never touches it.

Parameters:
C_MEMSIZE, 'h8000, BRAM size in bytes; byte addresses at or above this are out of range
C_PORT_AWIDTH, 32, address width
C_PORT_DWIDTH, 32, data width; only 32 is supported
C_NUM_WE, 4, byte write enables
C_CNT_WIDTH, 16, injection counter width

Ports:
Clk  in  1  single clock; the same clock drives BRAM_Clk_B externally
Rst  in  1  asynchronous, active-high reset
Host_Req  in  1  level request, held until Host_Ack
Host_WE  in  [0:3]  byte write enables; 0000 means read
Host_Addr  in  [0:31]  byte address
Host_Wdata  in  [0:31]  write data
Host_Rdata  out  [0:31]  read data, valid while Host_Ack=1
Host_Ack  out  1  one-cycle completion pulse
Inj_Req  in  1  level request, held until Inj_Ack
Inj_Addr  in  [0:31]  byte address of target word
Inj_Mask  in  [0:31]  bits to flip
Inj_Ack  out  1  one-cycle completion pulse
Inj_Err  out  1  qualifies Inj_Ack: address out of range, no access made
Inj_Count  out  [0:C_CNT_WIDTH-1]  completed injections with a nonzero mask; saturating
Busy  out  1  FSM not in IDLE
BRAM_EN_B  out  1  port B enable
BRAM_WEN_B  out  [0:3]  port B write enables
BRAM_Addr_B  out  [0:31]  port B address; bits 30:31 forced to 0
BRAM_Dout_B  out  [0:31]  write data to BRAM
BRAM_Din_B  in  [0:31]  read data from BRAM, valid 1 cycle after an EN read

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, RR pointer selects Host, Inj_Count is 0.
- All outputs are registered. The request's address, data and mask are captured at grant.
- Arbitration (IDLE only):
  - One request pending: grant it.
  - Both pending: grant the requester not served last (round-robin).
  - Grant takes effect on the clock edge where IDLE samples the request.
- FSM states: IDLE, H_ACC, H_RDW, I_RD, I_RDW, I_WR, ACK.
- Host write, Host_WE != 0:
  - IDLE -> H_ACC drives EN=1, WEN=Host_WE, address and data.
  - -> ACK raises Host_Ack.
  - Grant-to-Ack latency: 2 cycles.
- Host read:
  - H_ACC drives EN=1, WEN=0.
  - H_RDW captures BRAM_Din_B.
  - ACK raises Host_Ack with Host_Rdata.
  - Latency: 3 cycles.
- Injection:
  - Out-of-range address (Inj_Addr >= C_MEMSIZE): go directly to ACK with Inj_Ack=Inj_Err=1. No port activity.
  - I_RD: EN=1, WEN=0.
  - I_RDW: capture data.
  - I_WR: EN=1, WEN=1111, Dout = captured data XOR Inj_Mask.
  - ACK: Inj_Ack=1.
  - Mask = 0: I_WR is skipped (I_RDW -> ACK) and the count is not incremented.
  - Inj_Count increments in ACK and saturates at all-ones.
  - Nominal latency: 4 cycles. No host access can interleave between the read and the write; the RMW is atomic.
- Port B idle (EN=0, WEN=0) in IDLE, H_RDW, I_RDW and ACK.
- ACK always returns to IDLE. A request still asserted in the cycle after its Ack is treated as a new request, so requesters must drop Req on Ack.
- Requests that arrive while Busy are held off with no Ack until the FSM returns to IDLE.
- Host_Rdata holds its last value outside Ack.
- Address bits 30:31 are ignored (word aligned).
- Reset asserted mid-transaction aborts immediately:
  - Outputs clear asynchronously and no Ack is issued.
  - A pending BRAM write may be lost; this is acceptable.

Test Plan:
- Host write WE=1111, addr 0x10, data 0xDEADBEEF, then host read 0x10 -> write Ack at cycle 2, Rdata=0xDEADBEEF with Ack at cycle 3 after read grant.
- Preload 0x20=0x0000FFFF, inject mask 0x80000001 -> port B shows read then write of 0x8000FFFE, Inj_Ack at 4 cycles, Inj_Count=1.
- Host and Inj requests asserted in the same cycle, twice back-to-back -> grant order Host, Inj, Host, Inj. No port B access to the host address between the I_RD and I_WR of an injection.
- Inject at 0x8000 -> Inj_Ack=Inj_Err=1 at cycle 1 after grant, EN_B stays 0, count unchanged. Mask 0 at a valid address -> no write cycle, count unchanged.
- Force Inj_Count to all-ones, then inject -> count stays all-ones.
- Assert Rst during I_RDW -> all outputs 0 asynchronously, no Inj_Ack, FSM in IDLE. A fresh Host request after reset is served normally.
